// File: rtl/sram_like_resp.sv
// sram_like_resp: SRAM-like slave, internal word memory, in-order responses.
// Define RANDOM_DELAY_EN to add LFSR-driven addr_ok/data_ok stalls.

module sram_like_resp #(
   parameter int ADDR_W    = 10,
   parameter int MAX_OUTST = 4,
   parameter int LAT       = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [PW:0]   FULL     = (PW + 1)'(MAX_OUTST);
   localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CD_ONE   = CW'(1);
   localparam logic [CW-1:0] CD_INIT  = CW'(LAT - 1);

   // Outstanding-request FIFO: {is_write, data, countdown} per slot
   logic             ent_wr_q   [MAX_OUTST];
   logic [31:0]      ent_data_q [MAX_OUTST];
   logic [CW-1:0]    ent_cd_q   [MAX_OUTST];

   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    wptr_d;
   logic [PW-1:0]    rptr_q;
   logic [PW-1:0]    rptr_d;
   logic [PW:0]      cnt_q;
   logic [PW:0]      cnt_d;

   logic [31:0]      mem_q [DEPTH];
   logic [ADDR_W-1:0] idx;

   logic             push;
   logic             pop;
   logic             head_rdy;
   logic             gate_a;
   logic             gate_d;

   // Access size and non-index address bits have no effect on the word store
   logic             unused_bits;
   assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

   assign idx = addr[ADDR_W+1:2];

`ifdef RANDOM_DELAY_EN
   logic [15:0]      lfsr_q;
   logic [15:0]      lfsr_d;

   // Taps 16,14,13,11 in right-shift Fibonacci form
   assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                    lfsr_q[15:1]};

   // Stall pattern generator, reseeded on every reset
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign gate_a = lfsr_q[0];
   assign gate_d = lfsr_q[1];
`else
   assign gate_a = 1'b1;
   assign gate_d = 1'b1;
`endif

   // A slot freed by this cycle's pop is not reusable until next cycle
   assign addr_ok  = !reset && (cnt_q < FULL) && gate_a;

   assign head_rdy = (cnt_q != '0) && (ent_cd_q[rptr_q] == '0);
   assign data_ok  = !reset && head_rdy && gate_d;

   assign rdata    = (data_ok && !ent_wr_q[rptr_q]) ?
                     ent_data_q[rptr_q] : 32'h0;

   assign push = req && addr_ok;
   assign pop  = data_ok;

   // Next-state for pointers and occupancy count
   always_comb begin
      wptr_d = push ? wptr_q + PTR_ONE : wptr_q;
      rptr_d = pop  ? rptr_q + PTR_ONE : rptr_q;
      cnt_d  = cnt_q;
      unique case (1'b1)
         push && !pop: cnt_d = cnt_q + CNT_ONE;
         pop && !push: cnt_d = cnt_q - CNT_ONE;
         default:      cnt_d = cnt_q;
      endcase
   end

   // FIFO control state; reset drops every pending response
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Slot payload: load on push, otherwise count down toward ready
   always_ff @(posedge clk) begin
      for (int i = 0; i < MAX_OUTST; i++) begin
         if (push && (wptr_q == PW'(i))) begin
            ent_wr_q[i]   <= wr;
            ent_data_q[i] <= mem_q[idx];
            ent_cd_q[i]   <= CD_INIT;
         end else if (ent_cd_q[i] != '0) begin
            ent_cd_q[i]   <= ent_cd_q[i] - CD_ONE;
         end
      end
   end

   // Byte-masked write into the word store; contents survive reset
   always_ff @(posedge clk) begin
      if (push && wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
               mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_like_resp.sv
// tb_sram_like_resp: scoreboard bench, two instances (LAT=1 and LAT=4).
// Directed vectors plus a model-checked random run on the LAT=1 instance.

module tb_sram_like_resp;

   localparam int LAT_A = 1;
   localparam int LAT_B = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic [1:0]       req_v = '0;
   logic [1:0]       wr_v = '0;
   logic [1:0][1:0]  size_v = '0;
   logic [1:0][31:0] addr_v = '0;
   logic [1:0][3:0]  wstrb_v = '0;
   logic [1:0][31:0] wdata_v = '0;
   wire  [1:0]       addr_ok_v;
   wire  [1:0]       data_ok_v;
   wire  [1:0][31:0] rdata_v;

   sram_like_resp #(.ADDR_W(10), .MAX_OUTST(4), .LAT(LAT_A)) u_dut_a (
      .clk(clk), .reset(reset),
      .req(req_v[0]), .wr(wr_v[0]), .size(size_v[0]),
      .addr(addr_v[0]), .wstrb(wstrb_v[0]), .wdata(wdata_v[0]),
      .addr_ok(addr_ok_v[0]), .data_ok(data_ok_v[0]),
      .rdata(rdata_v[0])
   );

   sram_like_resp #(.ADDR_W(10), .MAX_OUTST(4), .LAT(LAT_B)) u_dut_b (
      .clk(clk), .reset(reset),
      .req(req_v[1]), .wr(wr_v[1]), .size(size_v[1]),
      .addr(addr_v[1]), .wstrb(wstrb_v[1]), .wdata(wdata_v[1]),
      .addr_ok(addr_ok_v[1]), .data_ok(data_ok_v[1]),
      .rdata(rdata_v[1])
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] d;
      int          acc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t mon_e;
   exp_t mon_h;

   int n_chk = 0;
   int n_fail = 0;
   int astall = 0;
   int dstall0 = 0;
   int dstall1 = 0;
   int st;

   logic [31:0] mdl [2][1024];

   function automatic int lat_of(input int d);
      return (d == 0) ? LAT_A : LAT_B;
   endfunction

   function int qsz(input int d);
      return (d == 0) ? qa.size() : qb.size();
   endfunction

   function exp_t qhd(input int d);
      return (d == 0) ? qa[0] : qb[0];
   endfunction

   task qpop(input int d);
      if (d == 0) void'(qa.pop_front());
      else void'(qb.pop_front());
   endtask

   task qpush(input int d, input exp_t e);
      if (d == 0) qa.push_back(e);
      else qb.push_back(e);
   endtask

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)",
                  nm, act, want, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever a DUT raises data_ok
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            check("reset_addr_ok", 32'(addr_ok_v[d]), 32'h0);
            check("reset_data_ok", 32'(data_ok_v[d]), 32'h0);
            check("reset_rdata", rdata_v[d], 32'h0);
         end else if (data_ok_v[d]) begin
            if (qsz(d) == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_data_ok: dut %0d, got 1, expected 0 (cycle %0d)",
                        d, cyc);
            end else begin
               mon_e = qhd(d);
               qpop(d);
               check("rdata", rdata_v[d], mon_e.d);
`ifndef RANDOM_DELAY_EN
               check("latency", 32'(cyc), 32'(mon_e.acc + lat_of(d)));
`endif
            end
         end else begin
            check("rdata_idle", rdata_v[d], 32'h0);
            if (qsz(d) != 0) begin
               mon_h = qhd(d);
               if (cyc >= mon_h.acc + lat_of(d)) begin
`ifdef RANDOM_DELAY_EN
                  if (d == 0) dstall0++;
                  else dstall1++;
`else
                  n_chk++;
                  n_fail++;
                  $display("FAIL missing_data_ok: dut %0d, got 0, expected 1 (cycle %0d)",
                           d, cyc);
`endif
               end
            end
         end
      end
   end

   task automatic issue(input int d, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] wd,
                        input logic [1:0] sz, input logic [31:0] xv,
                        input bit use_x, output int stalls);
      exp_t e;
      logic [9:0] ix;
      bit done;
      req_v[d]   = 1'b1;
      wr_v[d]    = w;
      addr_v[d]  = a;
      wstrb_v[d] = s;
      wdata_v[d] = wd;
      size_v[d]  = sz;
      ix = a[11:2];
      stalls = 0;
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (addr_ok_v[d]) begin
            e.acc = cyc;
            if (w) begin
               e.d = 32'h0;
               for (int b = 0; b < 4; b++)
                  if (s[b]) mdl[d][ix][8*b +: 8] = wd[8*b +: 8];
            end else begin
               e.d = use_x ? xv : mdl[d][ix];
            end
            qpush(d, e);
            done = 1'b1;
         end else begin
            stalls++;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL issue_timeout: dut %0d, got no addr_ok, expected acceptance", d);
      end
      astall += stalls;
   endtask

   task automatic wr_t(input int d, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] wd,
                       input logic [1:0] sz);
      int sx;
      issue(d, 1'b1, a, s, wd, sz, 32'h0, 1'b0, sx);
   endtask

   task automatic rd_t(input int d, input logic [31:0] a,
                       input logic [31:0] xv, input logic [1:0] sz,
                       output int sx);
      issue(d, 1'b0, a, 4'h0, 32'h0, sz, xv, 1'b1, sx);
   endtask

   task automatic idle(input int d);
      req_v[d] = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 400 && (qa.size() + qb.size()) != 0; k++)
         @(posedge clk);
      #1;
      check("drain_empty", 32'(qa.size() + qb.size()), 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      logic [31:0] rd;
      logic        rw;
      logic [3:0]  rs;
      logic [1:0]  rz;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("addr_ok_after_reset_a", 32'(addr_ok_v[0]), 32'h1);
      check("addr_ok_after_reset_b", 32'(addr_ok_v[1]), 32'h1);
      @(posedge clk);
      #1;

      // Write then read of the same word, back to back
      wr_t(0, 32'h10, 4'hF, 32'h12345678, 2'd2);
      rd_t(0, 32'h10, 32'h12345678, 2'd0, st);
      idle(0);

      // Partial byte write, size ignored
      wr_t(0, 32'h20, 4'hF, 32'hFFFFFFFF, 2'd2);
      wr_t(0, 32'h20, 4'b0010, 32'h0000AB00, 2'd0);
      rd_t(0, 32'h20, 32'hFFFFABFF, 2'd1, st);

      // Address aliasing above bit 11
      wr_t(0, 32'h1000, 4'hF, 32'hA5A5A5A5, 2'd2);
      rd_t(0, 32'h0000, 32'hA5A5A5A5, 2'd2, st);
      rd_t(0, 32'hFFFFF022, 32'hFFFFABFF, 2'd3, st);
      idle(0);
      drain();

      // Fill the LAT=4 FIFO, fifth request must wait one cycle
      for (int i = 0; i < 4; i++)
         wr_t(1, 32'(i * 4), 4'hF, 32'h10000000 + 32'(i), 2'd2);
      idle(1);
      drain();
      for (int i = 0; i < 4; i++)
         rd_t(1, 32'(i * 4), 32'h10000000 + 32'(i), 2'd2, st);
      rd_t(1, 32'h8, 32'h10000002, 2'd2, st);
`ifndef RANDOM_DELAY_EN
      check("full_fifo_stall_cycles", 32'(st), 32'h1);
`endif
      idle(1);
      drain();

      // Reset with three reads in flight
      wr_t(1, 32'h40, 4'hF, 32'hDEADBEEF, 2'd2);
      idle(1);
      drain();
      rd_t(1, 32'h40, 32'hDEADBEEF, 2'd2, st);
      rd_t(1, 32'h0, 32'h10000000, 2'd2, st);
      rd_t(1, 32'h4, 32'h10000001, 2'd2, st);
      idle(1);
      qa.delete();
      qb.delete();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("addr_ok_after_midreset", 32'(addr_ok_v[1]), 32'h1);
      repeat (10) @(posedge clk);
      #1;
      rd_t(1, 32'h40, 32'hDEADBEEF, 2'd2, st);
      idle(1);
      drain();

      // Random traffic against the reference model
      for (int w = 0; w < 16; w++)
         wr_t(0, 32'(w * 4), 4'hF, $urandom, 2'd2);
      for (int i = 0; i < 1000; i++) begin
         rw = 1'($urandom_range(0, 1));
         ra = ($urandom & 32'hFFFFF000) |
              (32'($urandom_range(0, 15)) << 2) |
              32'($urandom_range(0, 3));
         rs = 4'($urandom_range(0, 15));
         rd = $urandom;
         rz = 2'($urandom_range(0, 3));
         issue(0, rw, ra, rs, rd, rz, 32'h0, 1'b0, st);
         if ($urandom_range(0, 3) == 0) begin
            idle(0);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      idle(0);
      drain();

`ifdef RANDOM_DELAY_EN
      check("addr_ok_stalls_seen", 32'(astall > 0), 32'h1);
      check("data_ok_stalls_seen", 32'(dstall0 + dstall1 > 0), 32'h1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
